alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//   Shares the single combinational ALU between NUM_REQ requesters (e.g. execute stage, address unit).
//   Round-robin arbitration, valid/ready request and response handshakes, registered ALU operands
//   and registered result. Sits between the requesters and one ALU instance; owns the ALU input ports.
// PARAMETERS
//   NUM_REQ         2   number of requesters, legal range 2..4
//   REGISTER_WIDTH  8   operand/result width (matches parameters.h)
//   OPCODE_WIDTH    4   ALU opcode width (matches parameters.h)
// PORTS
//   clock       in   1                        single clock, rising edge
//   reset       in   1                        asynchronous, active-high
//   req_valid   in   NUM_REQ                  request pending, one bit per requester
//   req_opcode  in   NUM_REQ*OPCODE_WIDTH     opcode of requester i in slice i
//   req_reg1    in   NUM_REQ*REGISTER_WIDTH   operand 1 of requester i in slice i
//   req_reg2    in   NUM_REQ*REGISTER_WIDTH   operand 2 of requester i in slice i
//   req_ready   out  NUM_REQ                  request accepted this cycle; one-hot or zero
//   rsp_valid   out  NUM_REQ                  result available for requester i; one-hot or zero
//   rsp_result  out  REGISTER_WIDTH           result, shared by all requesters
//   rsp_ready   in   NUM_REQ                  requester i takes the result
//   alu_opcode  out  OPCODE_WIDTH             to ALU opCode
//   alu_reg1    out  REGISTER_WIDTH           to ALU register1Value
//   alu_reg2    out  REGISTER_WIDTH           to ALU register2Value
//   alu_result  in   REGISTER_WIDTH           from ALU aluResult (combinational)
//   busy        out  1                        state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, ptr=0, grant_id=0; alu_opcode/alu_reg1/alu_reg2/rsp_result=0.
//     rsp_valid=0, req_ready=0, busy=0. Takes effect immediately, independent of clock.
//   States: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//     - winner = first i with req_valid[i], scanning from ptr upward with wrap to 0.
//     - req_ready[winner]=1 combinationally in the same cycle; the handshake completes on that edge.
//     - On that edge: latch winner's opcode/reg1/reg2 into alu_* registers, grant_id<=winner, go EXEC.
//     - No valid request: stay IDLE; alu_* registers hold their previous values.
//   EXEC:
//     - alu_* held; ALU settles within the cycle.
//     - At the edge: rsp_result<=alu_result, go RESP.
//   RESP:
//     - rsp_valid[grant_id]=1; rsp_result held stable until the handshake.
//     - On rsp_ready[grant_id]=1: ptr<=(grant_id+1) mod NUM_REQ, go IDLE. rsp_valid drops the next cycle.
//   req_ready is 0 outside IDLE; requests arriving in EXEC/RESP wait (requester holds valid).
//   A requester dropping req_valid before acceptance is never served; no state change.
//   rsp_ready on a non-granted line is ignored.
//   Latency: accept at edge T; rsp_valid high from cycle T+2. Minimum 3 cycles per operation.
//   Opcodes are passed through undecoded; the ALU returns 0 for unsupported opcodes.
//   Fairness: a requester that keeps req_valid high waits at most NUM_REQ-1 operations.
//   Widths: no arithmetic here beyond the ptr wrap; the result is the ALU's REGISTER_WIDTH value
//     (carry dropped by the ALU).
//   Reset mid-operation: the in-flight op is discarded, no response is issued, ptr returns to 0.
// TESTING
//   1 req0 ADD2 0x05,0x03 at edge T -> req_ready[0] at T; rsp_valid[0] at T+2, rsp_result=0x08;
//     busy high T+1 until the handshake.
//   2 req0 and req1 both valid continuously, rsp_ready=all 1s -> grants alternate 0,1,0,1,...;
//     each rsp_valid appears on the matching line only.
//   3 rsp_ready[0] held low 5 cycles -> rsp_valid[0]/rsp_result stable; req_ready[1] stays 0 despite req1 valid.
//   4 Wrap cases: ADD2 0xFF+0x02 -> 0x01; INCREMENT11 0xFF -> 0x00; DECREMENT14 0x00 -> 0xFF;
//     RSHIFT15 0x01 -> 0x80; LSHIFT13 0x80 -> 0x01.
//   5 reset pulsed during EXEC -> all outputs 0 immediately, no rsp_valid;
//     with req1 and req0 both valid afterwards, req0 is granted first.
//   6 In RESP for req0, assert rsp_ready[1] only -> ignored, rsp_valid[0] stays high; unsupported opcode -> result 0x00.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// Latency: request accepted at edge T, registered result offered from cycle T+2; at least 3 cycles per op.
// Backpressure: one op in flight; req_ready is held low until the granted requester takes its result.
module alu_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int REGISTER_WIDTH = 8,
   parameter int OPCODE_WIDTH   = 4
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*OPCODE_WIDTH-1:0]    req_opcode,
   input  logic [NUM_REQ*REGISTER_WIDTH-1:0]  req_reg1,
   input  logic [NUM_REQ*REGISTER_WIDTH-1:0]  req_reg2,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic [NUM_REQ-1:0]                 rsp_valid,
   output logic [REGISTER_WIDTH-1:0]          rsp_result,
   input  logic [NUM_REQ-1:0]                 rsp_ready,
   output logic [OPCODE_WIDTH-1:0]            alu_opcode,
   output logic [REGISTER_WIDTH-1:0]          alu_reg1,
   output logic [REGISTER_WIDTH-1:0]          alu_reg2,
   input  logic [REGISTER_WIDTH-1:0]          alu_result,
   output logic                               busy
);

   localparam int PW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ptr;
   logic [PW-1:0] grant_id;
   logic [PW-1:0] winner;
   logic          found;
   logic [PW:0]   sum;
   logic [PW-1:0] cand;
   logic          rsp_done;

   // Round-robin scan: first valid requester at or after ptr, wrapping to 0.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NUM_REQ)) begin
            sum = sum - (PW+1)'(NUM_REQ);
         end
         cand = sum[PW-1:0];
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign rsp_done = rsp_ready[grant_id];

   // State register; reset drops any in-flight op without responding.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; only the granted line is ever asserted.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (found) begin
               req_ready[winner] = 1'b1;
               state_nxt         = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid[grant_id] = 1'b1;
            if (rsp_done) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture on accept, result capture after the ALU settles, pointer advance on completion.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr        <= '0;
         grant_id   <= '0;
         alu_opcode <= '0;
         alu_reg1   <= '0;
         alu_reg2   <= '0;
         rsp_result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id   <= winner;
                  alu_opcode <= req_opcode[winner*OPCODE_WIDTH +: OPCODE_WIDTH];
                  alu_reg1   <= req_reg1[winner*REGISTER_WIDTH +: REGISTER_WIDTH];
                  alu_reg2   <= req_reg2[winner*REGISTER_WIDTH +: REGISTER_WIDTH];
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
            end
            RESP: begin
               if (rsp_done) begin
                  if (grant_id == PW'(NUM_REQ-1)) begin
                     ptr <= '0;
                  end else begin
                     ptr <= grant_id + PW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
